decoder_scan: RTL and testbench

//   Parametrised registered binary-to-one-hot decoder with a built-in scan sequencer.

---
 rtl/decoder_scan.sv | 79 +++++++
 tb/tb_decoder_scan.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a prescaled scan sequencer.
// Direct mode decodes sel; scan mode steps the active output through 0..OUT_W-1.
module decoder_scan #(
  parameter int SEL_W      = 3,
  parameter int OUT_W      = 8,
  parameter int DIV        = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  output logic [OUT_W-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam int              PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
  localparam logic [SEL_W:0]  LAST     = (SEL_W + 1)'(OUT_W - 1);
  localparam logic            INACT    = (ACTIVE_LOW != 0);

  logic [PW-1:0]    pre_q, pre_d;
  logic [SEL_W-1:0] idx_d;
  logic [OUT_W-1:0] y_d;
  logic             wrap_d;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] k);
    logic [OUT_W-1:0] v;
    v = {OUT_W{INACT}};
    for (int unsigned i = 0; i < OUT_W; i++)
      if ({1'b0, k} == (SEL_W + 1)'(i)) v[i] = ~INACT;
    return v;
  endfunction

  always_comb begin
    idx_d  = idx;
    pre_d  = pre_q;
    wrap_d = 1'b0;
    if (en) begin
      if (!mode) begin
        idx_d = sel;
        pre_d = '0;
      end else if (load) begin
        idx_d = ({1'b0, sel} > LAST) ? '0 : sel;
        pre_d = '0;
      end else if (pre_q == PRE_LAST) begin
        pre_d = '0;
        // an out-of-range idx left by direct mode behaves like the last index
        if ({1'b0, idx} >= LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx + 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    y_d = en ? decode(idx_d) : {OUT_W{INACT}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y     <= {OUT_W{INACT}};
      idx   <= '0;
      pre_q <= '0;
      wrap  <= 1'b0;
    end else begin
      y     <= y_d;
      idx   <= idx_d;
      pre_q <= pre_d;
      wrap  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: default instance plus OUT_W=6, DIV=1,
// active-low instance sharing the same stimulus.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n, en, mode, load;
  logic [2:0] sel;
  logic [7:0] y0;
  logic [2:0] idx0;
  logic       wrap0;
  logic [5:0] y1;
  logic [2:0] idx1;
  logic       wrap1;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .OUT_W(8), .DIV(4), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y0), .idx(idx0), .wrap(wrap0)
  );

  decoder_scan #(.SEL_W(3), .OUT_W(6), .DIV(1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .load(load),
    .y(y1), .idx(idx1), .wrap(wrap1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] oh8(input int k);
    logic [7:0] v;
    v = '0;
    if (k < 8) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [5:0] oc6(input int k);
    logic [5:0] v;
    v = '1;
    if (k < 6) v[k] = 1'b0;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; sel = '0;
    step(3);
    chk("rst_y0", y0, 8'h00);
    chk("rst_idx0", idx0, 0);
    chk("rst_wrap0", wrap0, 0);
    chk("rst_y1", y1, 6'h3F);
    chk("rst_idx1", idx1, 0);
    rst_n = 1'b1;

    // direct decode
    en = 1'b1; sel = 3'd5;
    step(1);
    chk("dir5_y0", y0, 8'b0010_0000);
    chk("dir5_idx0", idx0, 5);
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step(1);
      chk("sweep_y0", y0, oh8(i));
      chk("sweep_idx0", idx0, i);
      chk("sweep_y1", y1, oc6(i));
      chk("sweep_idx1", idx1, i);
      chk("sweep_wrap0", wrap0, 0);
    end
    en = 1'b0;
    step(1);
    chk("dis_y0", y0, 8'h00);
    chk("dis_idx0", idx0, 7);
    chk("dis_y1", y1, 6'h3F);

    // scan from idx 0
    en = 1'b1; sel = 3'd0;
    step(1);
    chk("pre_scan_idx0", idx0, 0);
    mode = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step(1);
      chk("scan_idx0", idx0, (k / 4) % 8);
      chk("scan_y0", y0, oh8((k / 4) % 8));
      chk("scan_wrap0", wrap0, (k % 4 == 0) && ((k / 4) % 8 == 0));
      chk("scan_idx1", idx1, k % 6);
      chk("scan_y1", y1, oc6(k % 6));
      chk("scan_wrap1", wrap1, k % 6 == 0);
    end

    // load on a tick cycle
    step(3);
    chk("pretick_idx0", idx0, 0);
    chk("pretick_idx1", idx1, 5);
    load = 1'b1; sel = 3'd3;
    step(1);
    load = 1'b0;
    chk("ld3_idx0", idx0, 3);
    chk("ld3_wrap0", wrap0, 0);
    chk("ld3_idx1", idx1, 3);
    step(3);
    chk("ld3_hold_idx0", idx0, 3);
    step(1);
    chk("ld3_step_idx0", idx0, 4);
    chk("ld3_step_y0", y0, 8'h10);
    chk("ld3_step_idx1", idx1, 1);

    // load out of range for the 6-wide instance
    load = 1'b1; sel = 3'd7;
    step(1);
    chk("ld7_idx0", idx0, 7);
    chk("ld7_idx1", idx1, 0);
    chk("ld7_y1", y1, 6'h3E);
    chk("ld7_wrap1", wrap1, 0);
    sel = 3'd6;
    step(1);
    load = 1'b0;
    chk("ld6_idx0", idx0, 6);
    chk("ld6_idx1", idx1, 0);

    // reset mid-scan
    step(1);
    rst_n = 1'b0;
    step(1);
    chk("midrst_y0", y0, 8'h00);
    chk("midrst_idx0", idx0, 0);
    chk("midrst_wrap0", wrap0, 0);
    chk("midrst_y1", y1, 6'h3F);
    chk("midrst_idx1", idx1, 0);
    rst_n = 1'b1;
    step(3);
    chk("resume_hold_idx0", idx0, 0);
    step(1);
    chk("resume_step_idx0", idx0, 1);
    chk("resume_idx1", idx1, 4);

    // enable freeze mid-scan (dut0 prescaler left at 2)
    step(2);
    chk("prefrz_idx0", idx0, 1);
    chk("prefrz_idx1", idx1, 0);
    chk("prefrz_wrap1", wrap1, 1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("frz_y0", y0, 8'h00);
      chk("frz_idx0", idx0, 1);
      chk("frz_idx1", idx1, 0);
      chk("frz_wrap1", wrap1, 0);
    end
    en = 1'b1;
    step(1);
    chk("unfrz_idx0", idx0, 1);
    chk("unfrz_y0", y0, 8'h02);
    chk("unfrz_idx1", idx1, 1);
    step(1);
    chk("unfrz_step_idx0", idx0, 2);
    chk("unfrz_step_y0", y0, 8'h04);

    // scan -> direct, then out-of-range idx entering scan
    mode = 1'b0; sel = 3'd2;
    step(1);
    chk("todir_idx0", idx0, 2);
    chk("todir_y0", y0, 8'h04);
    sel = 3'd7;
    step(1);
    chk("dir7_idx1", idx1, 7);
    chk("dir7_y1", y1, 6'h3F);
    mode = 1'b1;
    step(1);
    chk("oor_idx1", idx1, 0);
    chk("oor_wrap1", wrap1, 1);
    chk("oor_y1", y1, 6'h3E);
    chk("oor_hold_idx0", idx0, 7);
    step(3);
    chk("oor_idx0", idx0, 0);
    chk("oor_wrap0", wrap0, 1);
    chk("oor_y0", y0, 8'h01);
    step(1);
    chk("oor_wrap0_end", wrap0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
